core_sequencer: RTL

- Multi-cycle control FSM for the RV32IM core.
- Sits between the instruction decoder's class flags and the datapath: it steps one instruction through fetch, decode, execute, memory and writeback.
- Drives the instruction/data memory handshakes, the mul/div unit start/done handshake and the register-file and PC write enables.
- Detects illegal opcodes and memory timeouts, and counts retired instructions.

---
 rtl/core_sequencer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle control FSM for the RV32IM core.
// Steps one instruction through fetch/decode/exec/muldiv/mem/wb.
module core_sequencer #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int INSTRET_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 imem_req,
  input  logic                 imem_ready,
  output logic                 ir_we,
  input  logic                 arithmetic,
  input  logic                 arithmetic_imm,
  input  logic                 load,
  input  logic                 store,
  input  logic                 branch,
  input  logic                 jal,
  input  logic                 jalr,
  input  logic                 lui,
  input  logic                 auipc,
  input  logic [6:0]           funct7,
  input  logic [4:0]           rd,
  output logic                 muldiv_start,
  input  logic                 muldiv_done,
  output logic                 dmem_req,
  output logic                 dmem_we,
  input  logic                 dmem_ready,
  output logic                 rf_we,
  output logic                 pc_we,
  output logic [2:0]           state,
  output logic                 trap,
  output logic [1:0]           trap_cause,
  output logic [INSTRET_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MULDIV = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t        cur, nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    cause_nxt;
  logic          any_flag, is_muldiv, at_limit;

  assign state     = cur;
  assign any_flag  = |{arithmetic, arithmetic_imm, load, store,
                       branch, jal, jalr, lui, auipc};
  assign is_muldiv = arithmetic && (funct7 == 7'b0000001);
  // Current cycle is the TIMEOUT_CYCLES-th wait cycle
  assign at_limit  = (cnt >= LAST);

  always_comb begin
    nxt          = cur;
    cnt_nxt      = '0;
    cause_nxt    = trap_cause;
    imem_req     = 1'b0;
    ir_we        = 1'b0;
    muldiv_start = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    rf_we        = 1'b0;
    pc_we        = 1'b0;
    case (cur)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we = 1'b1;
          nxt   = S_DECODE;
        end else if (at_limit) begin
          nxt       = S_TRAP;
          cause_nxt = 2'd2;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_DECODE: begin
        if (!any_flag) begin
          nxt       = S_TRAP;
          cause_nxt = 2'd1;
        end else begin
          nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_muldiv) begin
          muldiv_start = 1'b1;
          nxt          = S_MULDIV;
        end else if (load || store) begin
          nxt = S_MEM;
        end else if (branch) begin
          pc_we = 1'b1;
          nxt   = S_FETCH;
        end else begin
          nxt = S_WB;
        end
      end
      S_MULDIV: begin
        if (muldiv_done) nxt = S_WB;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = store;
        if (dmem_ready) begin
          if (store) begin
            pc_we = 1'b1;
            nxt   = S_FETCH;
          end else begin
            nxt = S_WB;
          end
        end else if (at_limit) begin
          nxt       = S_TRAP;
          cause_nxt = 2'd3;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_WB: begin
        rf_we = (rd != 5'd0);
        pc_we = 1'b1;
        nxt   = S_FETCH;
      end
      S_TRAP: nxt = S_TRAP;
      default: nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur        <= S_FETCH;
      cnt        <= '0;
      trap       <= 1'b0;
      trap_cause <= 2'd0;
      instret    <= '0;
    end else begin
      cur        <= nxt;
      cnt        <= cnt_nxt;
      trap       <= trap | (nxt == S_TRAP);
      trap_cause <= cause_nxt;
      if (pc_we) instret <= instret + INSTRET_W'(1);
    end
  end

endmodule
